// File: rtl/dl_sequencer.sv
// ROM download and core reset sequencer between hps_io and the arcade core.
// Registers range-checked download writes onto the core's ROM load port,
// counts accepted bytes, holds the core in reset through and after loading,
// and stretches user reset requests to HOLD_CYCLES.
// Optional build macro: DL_CHECKSUM_EN adds a mod-256 byte sum to the
// good-image test (sum must equal EXPECT_SUM).
module dl_sequencer #(
    parameter int unsigned EXPECT_BYTES = 20480,
    parameter int unsigned HOLD_CYCLES  = 1024,
    parameter logic [7:0]  EXPECT_SUM   = 8'h00
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        rom_ready,
    output logic        dl_error,
    output logic [16:0] byte_count
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t              state;
    logic                dl_prev;
    logic                overflow;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                dl_rise;
    logic                dl_fall;
    logic                in_range;
    logic                wr_accept;
    logic                wr_reject;
    logic [16:0]         count_next;
    logic                overflow_next;
    logic                image_good;

    // Download edge detection against the registered previous level
    assign dl_rise = ioctl_download & ~dl_prev;
    assign dl_fall = ~ioctl_download & dl_prev;

    // Write classification; only writes seen while loading have any effect
    assign in_range      = 32'(ioctl_addr) < EXPECT_BYTES;
    assign wr_accept     = (state == ST_LOAD) & ioctl_wr & in_range;
    assign wr_reject     = (state == ST_LOAD) & ioctl_wr & ~in_range;
    assign count_next    = (wr_accept && (byte_count != '1)) ? byte_count + 17'd1 : byte_count;
    assign overflow_next = overflow | wr_reject;

`ifdef DL_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_next;

    // Running sum includes a byte accepted on the same cycle as the fall
    assign sum_next   = sum + (wr_accept ? ioctl_dout : 8'h00);
    assign image_good = (32'(count_next) == EXPECT_BYTES) & ~overflow_next
                      & (sum_next == EXPECT_SUM);
`else
    logic unused_expect_sum;

    // Image judged on byte count and overflow alone
    assign unused_expect_sum = ^EXPECT_SUM;
    assign image_good        = (32'(count_next) == EXPECT_BYTES) & ~overflow_next;
`endif

    // Sequencer state, write forwarding and registered outputs
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state      <= ST_BOOT;
            core_reset <= 1'b1;
            dn_wr      <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            rom_ready  <= 1'b0;
            dl_error   <= 1'b0;
            byte_count <= '0;
            hold_cnt   <= '0;
            overflow   <= 1'b0;
            dl_prev    <= 1'b0;
`ifdef DL_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            dl_prev    <= ioctl_download;
            dn_wr      <= 1'b0;
            byte_count <= count_next;
            overflow   <= overflow_next;
`ifdef DL_CHECKSUM_EN
            sum        <= sum_next;
`endif
            if (wr_accept) begin
                dn_wr   <= 1'b1;
                dn_addr <= ioctl_addr[15:0];
                dn_data <= ioctl_dout;
            end

            if (dl_rise) begin
                // A new download always restarts loading from a clean slate
                state      <= ST_LOAD;
                core_reset <= 1'b1;
                rom_ready  <= 1'b0;
                dl_error   <= 1'b0;
                byte_count <= '0;
                overflow   <= 1'b0;
`ifdef DL_CHECKSUM_EN
                sum        <= '0;
`endif
            end else begin
                case (state)
                    ST_BOOT: begin
                        core_reset <= 1'b1;
                    end
                    ST_LOAD: begin
                        core_reset <= 1'b1;
                        if (dl_fall) begin
                            if (image_good) begin
                                state    <= ST_HOLD;
                                hold_cnt <= HOLD_RELOAD;
                            end else begin
                                state    <= ST_FAULT;
                                dl_error <= 1'b1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (user_reset) begin
                            hold_cnt <= HOLD_RELOAD;
                        end else if (hold_cnt == '0) begin
                            state      <= ST_RUN;
                            rom_ready  <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (user_reset) begin
                            state      <= ST_HOLD;
                            hold_cnt   <= HOLD_RELOAD;
                            core_reset <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        core_reset <= 1'b1;
                        rom_ready  <= 1'b0;
                        dl_error   <= 1'b1;
                    end
                    default: begin
                        state      <= ST_BOOT;
                        core_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/dl_sequencer.md
Name: dl_sequencer

Overview:
Sequences ROM download and core reset for the arcade core. Sits between hps_io (ioctl_*) and scramble_top (dn_*, RESET). Registers and range-checks download writes into the core's ROM load port, and counts the accepted bytes. Holds the core in reset during and after loading, then releases it. Stretches user reset requests to a guaranteed minimum width.

Parameters:
EXPECT_BYTES, 20480, exact number of accepted writes required for a valid image; also the address limit.
HOLD_CYCLES, 1024, clk_sys cycles of core reset after a good load or after a user reset request (≥1).
EXPECT_SUM, 8'h00, expected mod-256 byte sum; used only with DL_CHECKSUM_EN.

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
RESET  in  1  synchronous, active-high reset
ioctl_download  in  1  download-active level from hps_io
ioctl_wr  in  1  one-cycle write strobe
ioctl_addr  in  25  download byte address
ioctl_dout  in  8  download byte
user_reset  in  1  OR of menu reset, status reset and button; level
dn_addr  out  16  ROM load address to the core
dn_data  out  8  ROM load data
dn_wr  out  1  ROM load strobe, one cycle
core_reset  out  1  reset to the core, active-high
rom_ready  out  1  valid image loaded
dl_error  out  1  last download rejected
byte_count  out  17  accepted writes in the current or last download

Behaviour:
- Reset (RESET=1): state=BOOT, core_reset=1, dn_wr=0, dn_addr=0, dn_data=0, rom_ready=0, dl_error=0, byte_count=0, hold counter=0, overflow=0, dl_prev=0.
- Edge detection uses registered dl_prev. Because dl_prev resets to 0, ioctl_download high at RESET release counts as a rise; LOAD is entered on the next cycle.
- States: BOOT, LOAD, HOLD, RUN, FAULT.
- BOOT: core_reset=1. On a rise of ioctl_download: go to LOAD, clear byte_count, overflow and sum.
- LOAD: core_reset=1, rom_ready=0, dl_error=0.
  - Accepted write: ioctl_wr=1 with ioctl_addr < EXPECT_BYTES.
  - One cycle later: dn_wr=1 for exactly one cycle, with dn_addr=ioctl_addr[15:0] and dn_data=ioctl_dout captured at the strobe. byte_count increments on the same cycle.
  - byte_count saturates at 2^17-1. Duplicate addresses count again.
  - A write with ioctl_addr ≥ EXPECT_BYTES is dropped (no dn_wr) and sets overflow.
- End of download: on the fall of ioctl_download, evaluate the image.
  - Image is good if the final count (including a write accepted on that same cycle) equals EXPECT_BYTES and overflow=0.
  - Good: go to HOLD with hold counter=HOLD_CYCLES-1.
  - Otherwise: go to FAULT.
- HOLD: core_reset=1.
  - Counter decrements each cycle. At 0, go to RUN with rom_ready=1 and core_reset=0 on the same edge.
  - A download rise aborts to LOAD.
  - user_reset during HOLD reloads the counter.
- RUN: core_reset=0, rom_ready=1.
  - user_reset=1: go to HOLD, reload counter, core_reset=1 on the next cycle. rom_ready stays 1.
  - A download rise goes to LOAD and clears rom_ready.
- FAULT: core_reset=1, dl_error=1, rom_ready=0. Exits only on a download rise (to LOAD) or on RESET.
- ioctl_wr outside LOAD is ignored: no dn_wr, no count change.
- Priority within one cycle: RESET > download rise > download fall > user_reset > counter expiry.
- Write latency is fixed at 1 cycle. Back-to-back strobes on consecutive cycles must all be forwarded.

Optional Feature:
DL_CHECKSUM_EN:
- Defined:
  - A running 8-bit sum (mod 256) accumulates every accepted byte.
  - The good-image condition also requires sum == EXPECT_SUM. A mismatch goes to FAULT.
  - The sum is cleared on entry to LOAD.
- Undefined: no sum logic; the image is judged by byte count and overflow only.

Test Plan:
- Good load: RESET, then a download of 20480 writes at addresses 0..20479 with data=addr[7:0]. Expect 20480 dn_wr pulses, each 1 cycle after its ioctl_wr with matching addr/data. byte_count=20480. core_reset stays 1 for 1024 cycles after the fall, then core_reset=0 and rom_ready=1.
- Short load: 20479 writes. Expect FAULT after the fall: dl_error=1, core_reset=1, rom_ready=0. A new full download then clears dl_error and reaches RUN.
- Overflow: 20480 good writes plus one write at address 20480. Expect no dn_wr for the extra write, byte_count=20480, FAULT.
- Boundary: the last write strobe coincides with the download fall. Expect it forwarded and counted; state goes to HOLD, not FAULT.
- User reset: in RUN, pulse user_reset for 1 cycle. Expect core_reset=1 for exactly 1024 cycles starting the next cycle, with rom_ready=1 throughout. Then assert user_reset again mid-HOLD; expect the counter to reload.
- Mid-operation reset: assert RESET during LOAD after 100 writes. Expect all outputs at their reset values next cycle. With download still high at release, expect re-entry to LOAD with byte_count=0.
